fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of decode/execute. It consumes `branch_taken`/`branch_target` from the branch unit as a redirect.
- Owns the PC register and issues in-order requests to instruction memory. Memory latency is variable and ≥1 cycle.
- Buffers responses paired with their PC in a small FIFO and hands them to decode over a valid/ready handshake.
- Discards wrong-path responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- DEPTH, 2, maximum (outstanding requests + buffered entries). Legal values: 2..8, power of 2.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- redirect_valid  in  1  branch_taken from the branch unit
- redirect_pc  in  32  branch_target from the branch unit
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, word aligned
- imem_req_ready  in  1  memory accepts the request
- imem_rsp_valid  in  1  response valid (in order, one per accepted request)
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  entry available to decode
- if_pc  out  32  PC of the presented instruction
- if_instr  out  32  instruction word
- if_fault  out  1  instruction-address-misaligned marker
- id_ready  in  1  decode accepts the entry

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC; FIFO empty; out_cnt=0; drop_cnt=0; fault latch=0.
  - Outputs: imem_req_valid=0, if_valid=0, if_fault=0, if_pc=0, if_instr=0, imem_req_addr=RESET_PC.
  - Reset mid-operation abandons all state. Responses to pre-reset requests are the memory's responsibility; the memory is reset together with this block.
- Request issue:
  - imem_req_valid = !redirect_valid && !fault && (out_cnt + fifo_count < DEPTH).
  - imem_req_addr = pc.
  - Request fire (valid && ready): pc <= pc+4 (wraps mod 2^32), out_cnt++.
- Response handling:
  - Each imem_rsp_valid decrements out_cnt.
  - If drop_cnt>0: the response is discarded and drop_cnt--.
  - Otherwise {pc_tag, data} is pushed into the FIFO. pc_tag comes from an internal in-order PC queue of DEPTH entries.
  - The credit rule guarantees the FIFO never overflows. An assertion checks that no push occurs when full.
- Decode handshake:
  - if_valid = FIFO non-empty; outputs are driven from the FIFO head.
  - Pop on if_valid && id_ready.
  - When if_valid=1 && id_ready=0, if_pc/if_instr/if_fault hold stable.
  - Combinational latency from response to if_valid: 1 cycle (registered FIFO write; read is the head).
- Redirect (redirect_valid=1 at posedge):
  - Takes priority over every other event in the same cycle.
  - FIFO cleared; no request issued; no pop counted toward the new path.
  - pc <= redirect_pc & 32'hFFFF_FFFC.
  - drop_cnt <= drop_cnt + out_cnt − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - fault <= (redirect_pc[1:0] != 0).
- Fault:
  - When fault=1, no requests are issued.
  - Once out_cnt==0, a single entry is pushed: pc = full misaligned redirect_pc, instr = 32'h0000_0013 (NOP), if_fault=1.
  - Fetch stays halted until the next redirect.
- Back-to-back redirects accumulate into drop_cnt. drop_cnt width is clog2(DEPTH)+1.
- Request and response in the same cycle: out_cnt is unchanged.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - Fetch entry typedef {pc[31:0], instr[31:0], fault}.
  - Width helper for clog2(DEPTH).
- One natural sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO with a flush input. It is instantiated for the response buffer and reused for the in-flight PC queue. The PC queue is flushed only by reset, never by redirect, because tags must stay aligned with outstanding responses.

Test Plan:
- Reset then free-run, 1-cycle memory, id_ready=1 → requests at 0x0, 0x4, 0x8 …; if_pc sequence 0x0, 0x4, 0x8 with matching data; steady state one instruction per cycle.
- Decode stall: id_ready=0 for 5 cycles with DEPTH=2 → at most 2 requests outstanding/buffered; if_pc/if_instr stable; after release, order preserved with no loss or duplicates.
- Redirect with 2 outstanding (3-cycle latency), redirect_pc=0x100 → both old responses discarded; next if_pc=0x100 then 0x104; imem_req_valid=0 in the redirect cycle.
- Redirect coincident with a response and a request fire → response dropped; pc=target; out_cnt/drop_cnt consistent, checked by assertion that no stale PC reaches decode.
- Redirect to 0x202 → no memory request; single entry if_pc=0x202, if_instr=0x00000013, if_fault=1; a later redirect to 0x300 resumes normal fetch.
- rst_n=0 mid-stream with a full FIFO → next cycle if_valid=0, imem_req_addr=RESET_PC; fetch restarts cleanly.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch slice.
//   NOP_INSTR      : instruction word presented with a misaligned-fetch fault
//   fetch_entry_t  : one decode-bound entry {pc, instr, fault}
//   cnt_w()        : width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch stage's external handshakes:
//   redirect_valid/redirect_pc           : redirect from the branch unit
//   imem_req_valid/addr/ready            : request channel to instruction memory
//   imem_rsp_valid/data                  : in-order response channel
//   if_valid/if_pc/if_instr/if_fault     : entry presented to decode
//   id_ready                             : decode accepts the entry
// Modports: master = fetch unit, slave = surrounding pipeline / memory.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic        id_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr,
    output if_valid, if_pc, if_instr, if_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr,
    input  if_valid, if_pc, if_instr, if_fault
  );
endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry FIFO (DEPTH a power of 2) with a flush input.
// The head entry is presented combinationally on o_rdata.
//   clk, rst_n    : clock, synchronous active-low reset
//   i_flush       : empty the FIFO (wins over push/pop)
//   i_push/i_wdata: write an entry (ignored when full)
//   i_pop         : drop the head entry (ignored when empty)
//   o_rdata       : head entry
//   o_empty/o_full/o_count : occupancy
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  logic [W-1:0]              i_wdata,
  input  logic                      i_pop,
  output logic [W-1:0]              o_rdata,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [cnt_w(DEPTH)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full  && !i_flush;
  assign w_pop  = i_pop  && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Callers size their traffic so a push never meets a full FIFO.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && o_full && !i_flush));

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Owns the PC, issues in-order requests to
// instruction memory, pairs each response with its PC and buffers it for
// decode. A redirect flushes the buffer and discards the responses still in
// flight; a misaligned redirect target halts fetch and presents a single
// faulting NOP entry carrying the misaligned PC.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fetch_unit_if.master (redirect, imem request/response, decode)
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int            CW      = cnt_w(DEPTH);
  localparam int            EW      = $bits(fetch_entry_t);
  localparam logic [CW:0]   OCC_MAX = (CW+1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_fault_pc;
  logic          r_fault;
  logic          r_fault_done;
  logic [CW-1:0] r_drop_cnt;

  logic          w_redirect;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp;
  logic          w_rsp_keep;
  logic          w_fault_push;
  logic          w_buf_push;
  logic          w_buf_pop;
  logic          w_buf_empty;
  logic          w_buf_full;
  logic [CW-1:0] w_buf_cnt;
  logic [31:0]   w_tag;
  logic          w_tag_empty;
  logic          w_tag_full;
  logic [CW-1:0] w_tag_cnt;
  logic [CW:0]   w_occ;
  fetch_entry_t  w_buf_wdata;
  fetch_entry_t  w_buf_head;

  // The PC-tag queue holds exactly one entry per outstanding request, so its
  // occupancy doubles as the outstanding-request count.
  assign w_redirect  = bus.redirect_valid;
  assign w_occ       = {1'b0, w_tag_cnt} + {1'b0, w_buf_cnt};
  assign w_req_valid = rst_n && !w_redirect && !r_fault && !w_tag_full &&
                       (w_occ < OCC_MAX);
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;
  assign w_rsp       = bus.imem_rsp_valid && !w_tag_empty;

  // A response survives only on the current path with no pending drops.
  assign w_rsp_keep   = w_rsp && !w_redirect && (r_drop_cnt == '0);
  // The fault entry waits until every wrong-path response has drained.
  assign w_fault_push = r_fault && !r_fault_done && !w_redirect &&
                        w_tag_empty && !w_buf_full;
  assign w_buf_push   = w_rsp_keep || w_fault_push;
  assign w_buf_pop    = !w_buf_empty && bus.id_ready && !w_redirect;

  always_comb begin
    w_buf_wdata = '{pc: w_tag, instr: bus.imem_rsp_data, fault: 1'b0};
    if (w_fault_push) begin
      w_buf_wdata = '{pc: r_fault_pc, instr: NOP_INSTR, fault: 1'b1};
    end
  end

  // Tags stay aligned with outstanding responses, so only reset clears them.
  fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (1'b0),
    .i_push  (w_req_fire),
    .i_wdata (r_pc),
    .i_pop   (w_rsp),
    .o_rdata (w_tag),
    .o_empty (w_tag_empty),
    .o_full  (w_tag_full),
    .o_count (w_tag_cnt)
  );

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_rsp_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_redirect),
    .i_push  (w_buf_push),
    .i_wdata (w_buf_wdata),
    .i_pop   (w_buf_pop),
    .o_rdata (w_buf_head),
    .o_empty (w_buf_empty),
    .o_full  (w_buf_full),
    .o_count (w_buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_fault      <= 1'b0;
      r_fault_done <= 1'b0;
      r_drop_cnt   <= '0;
    end else if (w_redirect) begin
      r_pc         <= bus.redirect_pc & 32'hFFFF_FFFC;
      r_fault      <= |bus.redirect_pc[1:0];
      r_fault_done <= 1'b0;
      // Every outstanding request is now wrong-path. Pending drops are already
      // part of the outstanding count, so repeated redirects accumulate
      // without counting a response twice; a response arriving right now is
      // discarded here and leaves the count.
      r_drop_cnt   <= w_tag_cnt - {{(CW-1){1'b0}}, w_rsp};
    end else begin
      if (w_req_fire)                  r_pc         <= r_pc + 32'd4;
      if (w_rsp && r_drop_cnt != '0)   r_drop_cnt   <= r_drop_cnt - CW'(1);
      if (w_fault_push)                r_fault_done <= 1'b1;
    end
  end

  // Full misaligned target, reported on the fault entry.
  always_ff @(posedge clk) begin
    if (w_redirect) r_fault_pc <= bus.redirect_pc;
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.if_valid       = !w_buf_empty;
  assign bus.if_pc          = w_buf_empty ? 32'd0 : w_buf_head.pc;
  assign bus.if_instr       = w_buf_empty ? 32'd0 : w_buf_head.instr;
  assign bus.if_fault       = !w_buf_empty && w_buf_head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory: in-order queue of accepted addresses with a due cycle each.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Stimulus knobs
  int   lat_min, lat_max, rdy_pct, idr_pct, redir_pct;
  logic rst_req;
  logic force_redir;
  logic [31:0] force_target;

  // Reference model: the architectural stream decode must see.
  logic [31:0] exp_pc, next_req, fault_pc;
  logic        fault_mode, fault_seen;
  logic        chk_rst;
  logic        hold_v, hold_fault;
  logic [31:0] hold_pc, hold_instr;
  logic        last_if_valid;
  int          n_consumed;
  logic [31:0] cons[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_pc     = RESET_PC;
    next_req   = RESET_PC;
    fault_mode = 1'b0;
    fault_seen = 1'b0;
    hold_v     = 1'b0;
  endtask

  task automatic observe();
    logic [31:0] tgt;
    int lat;
    if (!rst_n) begin
      check("req_valid_in_reset", {31'd0, bus.imem_req_valid}, 32'd0);
      model_reset();
      last_if_valid = 1'b0;
      return;
    end
    if (chk_rst) begin
      chk_rst = 1'b0;
      check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
      check("rst_if_fault", {31'd0, bus.if_fault}, 32'd0);
      check("rst_if_pc",    bus.if_pc, 32'd0);
      check("rst_if_instr", bus.if_instr, 32'd0);
      check("rst_req_addr", bus.imem_req_addr, RESET_PC);
    end
    last_if_valid = bus.if_valid;
    check("outstanding_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
    if (hold_v) begin
      check("hold_valid", {31'd0, bus.if_valid}, 32'd1);
      check("hold_pc",    bus.if_pc, hold_pc);
      check("hold_instr", bus.if_instr, hold_instr);
      check("hold_fault", {31'd0, bus.if_fault}, {31'd0, hold_fault});
      hold_v = 1'b0;
    end
    if (bus.imem_rsp_valid) void'(mq.pop_front());
    if (bus.redirect_valid) begin
      check("req_valid_on_redirect", {31'd0, bus.imem_req_valid}, 32'd0);
      tgt        = bus.redirect_pc;
      exp_pc     = tgt & 32'hFFFF_FFFC;
      next_req   = exp_pc;
      fault_mode = (tgt[1:0] != 2'b00);
      fault_pc   = tgt;
      fault_seen = 1'b0;
      return;
    end
    if (fault_mode) begin
      check("req_valid_in_fault", {31'd0, bus.imem_req_valid}, 32'd0);
    end else if (bus.imem_req_valid) begin
      check("req_addr", bus.imem_req_addr, next_req);
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      lat = int'($urandom_range(lat_max, lat_min));
      mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      next_req = next_req + 32'd4;
    end
    if (fault_mode && fault_seen) begin
      check("no_entry_after_fault", {31'd0, bus.if_valid}, 32'd0);
    end else if (bus.if_valid) begin
      if (fault_mode) begin
        check("fault_pc",    bus.if_pc, fault_pc);
        check("fault_instr", bus.if_instr, NOP_INSTR);
        check("fault_flag",  {31'd0, bus.if_fault}, 32'd1);
      end else begin
        check("if_pc",    bus.if_pc, exp_pc);
        check("if_instr", bus.if_instr, mem_word(exp_pc));
        check("if_fault", {31'd0, bus.if_fault}, 32'd0);
      end
      if (bus.id_ready) begin
        n_consumed++;
        if (fault_mode) fault_seen = 1'b1;
        else begin
          cons.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
      end else begin
        hold_v     = 1'b1;
        hold_pc    = bus.if_pc;
        hold_instr = bus.if_instr;
        hold_fault = bus.if_fault;
      end
    end
  endtask

  task automatic cycle();
    logic [31:0] t;
    @(negedge clk);
    rst_n = !rst_req;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = $urandom;
    if (!rst_req) begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mq[0].addr);
      end
      if (force_redir) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = force_target;
        force_redir        = 1'b0;
      end else if (redir_pct > 0 && int'($urandom_range(99, 0)) < redir_pct) begin
        t = {20'd0, 12'($urandom_range(4095, 0))};
        if ($urandom_range(7, 0) != 0) t[1:0] = 2'b00;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = t;
      end
    end
    bus.id_ready       = (int'($urandom_range(99, 0)) < idr_pct);
    bus.imem_req_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    #1;
    observe();
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic knobs(input int lmin, input int lmax, input int rdy, input int idr, input int rd);
    lat_min = lmin; lat_max = lmax; rdy_pct = rdy; idr_pct = idr; redir_pct = rd;
  endtask

  int guard;
  int base;

  initial begin
    rst_n = 1'b0;
    rst_req = 1'b1;
    force_redir = 1'b0;
    force_target = 32'd0;
    chk_rst = 1'b0;
    last_if_valid = 1'b0;
    n_consumed = 0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.id_ready       = 1'b0;
    model_reset();
    knobs(1, 1, 100, 100, 0);
    run(3);

    // Free run, 1-cycle memory, decode always ready
    rst_req = 1'b0;
    chk_rst = 1'b1;
    cons.delete();
    n_consumed = 0;
    run(40);
    check("free_run_progress", 32'(n_consumed >= 15), 32'd1);
    check("first_pc0", (cons.size() > 0) ? cons[0] : 32'hDEAD_BEEF, 32'h0);
    check("first_pc1", (cons.size() > 1) ? cons[1] : 32'hDEAD_BEEF, 32'h4);
    check("first_pc2", (cons.size() > 2) ? cons[2] : 32'hDEAD_BEEF, 32'h8);

    // Decode stall for 5 cycles, then release
    knobs(1, 1, 100, 0, 0);
    run(5);
    base = n_consumed;
    knobs(1, 1, 100, 100, 0);
    run(20);
    check("stall_release_progress", 32'(n_consumed - base >= 8), 32'd1);

    // Redirect to 0x100 with two requests in flight, 3-cycle memory
    knobs(3, 3, 100, 100, 0);
    guard = 0;
    while (mq.size() < 2 && guard < 50) begin cycle(); guard++; end
    check("two_outstanding", 32'(mq.size() >= 2), 32'd1);
    force_target = 32'h0000_0100;
    force_redir  = 1'b1;
    base = cons.size();
    guard = 0;
    while (cons.size() < base + 2 && guard < 60) begin cycle(); guard++; end
    check("redir_pc0", (cons.size() > base)     ? cons[base]     : 32'hDEAD_BEEF, 32'h100);
    check("redir_pc1", (cons.size() > base + 1) ? cons[base + 1] : 32'hDEAD_BEEF, 32'h104);

    // Randomized traffic with redirects (aligned and misaligned)
    knobs(1, 4, 70, 70, 5);
    base = n_consumed;
    run(1500);
    check("random_progress", 32'(n_consumed - base >= 50), 32'd1);

    // Misaligned redirect: single fault entry, fetch halted, then resume
    knobs(2, 2, 100, 100, 0);
    force_target = 32'h0000_0202;
    force_redir  = 1'b1;
    cycle();
    guard = 0;
    while (!fault_seen && guard < 40) begin cycle(); guard++; end
    check("fault_entry_seen", {31'd0, fault_seen}, 32'd1);
    run(10);
    force_target = 32'h0000_0300;
    force_redir  = 1'b1;
    base = cons.size();
    guard = 0;
    while (cons.size() < base + 3 && guard < 60) begin cycle(); guard++; end
    check("resume_pc0", (cons.size() > base)     ? cons[base]     : 32'hDEAD_BEEF, 32'h300);
    check("resume_pc2", (cons.size() > base + 2) ? cons[base + 2] : 32'hDEAD_BEEF, 32'h308);

    // Reset mid-stream with the buffer full
    knobs(1, 1, 100, 0, 0);
    run(8);
    check("buffer_full_before_reset", {31'd0, last_if_valid}, 32'd1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    chk_rst = 1'b1;
    knobs(1, 2, 90, 90, 0);
    base = cons.size();
    run(40);
    check("post_reset_first_pc", (cons.size() > base) ? cons[base] : 32'hDEAD_BEEF, RESET_PC);
    check("post_reset_progress", 32'(cons.size() - base >= 10), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
